decode_issue_queue: RTL and testbench

Three-write/three-read circular queue sitting directly upstream of the register alias table in the issue stage. It buffers decoded micro-ops from the 3-wide decoders and presents them in program order to the RAT. Each cycle it computes how many head entries may rename, from RAT rename credit (`rename_ready`) and LSQ credit (`lsq_alloc_ready`). It then drives `decode_valid` so that the RAT only ever consumes what can be allocated.

---
 rtl/issue_pkg.sv | 22 ++
 rtl/issue_grant_select.sv | 53 +++++
 rtl/decode_issue_queue.sv | 109 ++++++++++
 tb/tb_decode_issue_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and helpers for the decode issue queue: uop entry layout,
// architectural register width and the 3-bit credit-mask popcount.
package issue_pkg;

    localparam int ARCH_ADDR_W   = 5;
    localparam int UOP_PAYLOAD_W = 64;

    typedef struct packed {
        logic [ARCH_ADDR_W-1:0]   rs1;
        logic [ARCH_ADDR_W-1:0]   rs2;
        logic [ARCH_ADDR_W-1:0]   rd;
        logic                     rd_we;
        logic                     branch;
        logic                     ls;
        logic [UOP_PAYLOAD_W-1:0] payload;
    } uop_entry_t;

    function automatic logic [1:0] popcount3(input logic [2:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
    endfunction

endpackage

// File: rtl/issue_grant_select.sv
// Combinational dequeue grant for the three head slots of the issue queue.
// Build option: ISSUE_SINGLE_BRANCH_EN limits a dequeue group to one branch.
module issue_grant_select
    import issue_pkg::*;
#(
    parameter int PTR_W = 3
) (
    input  logic [PTR_W:0] count,
    input  logic [2:0]     rename_ready,
    input  logic [2:0]     lsq_alloc_ready,
    input  logic [2:0]     slot_ls,
    input  logic [2:0]     slot_branch,
    input  logic           flush,
    output logic [2:0]     grant,
    output logic [1:0]     deq_n
);

    logic [1:0] lsq_cap;
    logic [2:0] slot_ok;

    assign lsq_cap = popcount3(lsq_alloc_ready);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            localparam logic [2:0] UPTO = 3'((1 << (gi + 1)) - 1);
            logic [1:0] ls_cum;
            logic       br_conflict;

            // Load/stores in slots 0..gi must all fit in the LSQ credit.
            assign ls_cum = popcount3(slot_ls & UPTO);
`ifdef ISSUE_SINGLE_BRANCH_EN
            localparam logic [2:0] BEFORE = 3'((1 << gi) - 1);
            assign br_conflict = slot_branch[gi] && (|(slot_branch & BEFORE));
`else
            assign br_conflict = 1'b0;
`endif
            assign slot_ok[gi] = (count > (PTR_W + 1)'(gi)) && rename_ready[gi]
                               && (ls_cum <= lsq_cap) && !br_conflict;
        end
    endgenerate

    // Grants are a contiguous prefix starting at the head.
    assign grant[0] = slot_ok[0] && !flush;
    assign grant[1] = grant[0] && slot_ok[1];
    assign grant[2] = grant[1] && slot_ok[2];
    assign deq_n    = popcount3(grant);

`ifndef ISSUE_SINGLE_BRANCH_EN
    logic unused_branch;
    assign unused_branch = ^slot_branch;
`endif

endmodule

// File: rtl/decode_issue_queue.sv
// 3-in/3-out circular uop queue between the decoders and the RAT.
// Build option: ISSUE_SINGLE_BRANCH_EN (one branch per dequeue group).
module decode_issue_queue
    import issue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = UOP_PAYLOAD_W,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [2:0]             enq_valid,
    input  logic [ARCH_ADDR_W-1:0] enq_rs1_0, enq_rs1_1, enq_rs1_2,
    input  logic [ARCH_ADDR_W-1:0] enq_rs2_0, enq_rs2_1, enq_rs2_2,
    input  logic [ARCH_ADDR_W-1:0] enq_rd_0, enq_rd_1, enq_rd_2,
    input  logic                   enq_rd_we_0, enq_rd_we_1, enq_rd_we_2,
    input  logic                   enq_branch_0, enq_branch_1, enq_branch_2,
    input  logic                   enq_ls_0, enq_ls_1, enq_ls_2,
    input  logic [PAYLOAD_W-1:0]   enq_payload_0, enq_payload_1, enq_payload_2,
    output logic                   enq_ready,
    input  logic [2:0]             rename_ready,
    input  logic [2:0]             lsq_alloc_ready,
    output logic [2:0]             decode_valid,
    output logic [ARCH_ADDR_W-1:0] rs1_arch_0, rs1_arch_1, rs1_arch_2,
    output logic [ARCH_ADDR_W-1:0] rs2_arch_0, rs2_arch_1, rs2_arch_2,
    output logic [ARCH_ADDR_W-1:0] rd_arch_0, rd_arch_1, rd_arch_2,
    output logic                   rd_write_enable_0, rd_write_enable_1, rd_write_enable_2,
    output logic                   branch_0, branch_1, branch_2,
    output logic                   load_store_0, load_store_1, load_store_2,
    output logic [PAYLOAD_W-1:0]   payload_0, payload_1, payload_2,
    output logic [PTR_W:0]         queue_count
);

    localparam logic [PTR_W:0] ENQ_LIMIT = (PTR_W + 1)'(DEPTH - 3);

    uop_entry_t       mem_reg [DEPTH];
    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [PTR_W:0]   count_reg;

    uop_entry_t enq_entry [3];
    uop_entry_t deq_entry [3];
    logic [2:0] slot_ls, slot_branch, grant;
    logic [1:0] enq_n, deq_n;

    assign enq_entry[0] = {enq_rs1_0, enq_rs2_0, enq_rd_0, enq_rd_we_0, enq_branch_0, enq_ls_0, enq_payload_0};
    assign enq_entry[1] = {enq_rs1_1, enq_rs2_1, enq_rd_1, enq_rd_we_1, enq_branch_1, enq_ls_1, enq_payload_1};
    assign enq_entry[2] = {enq_rs1_2, enq_rs2_2, enq_rd_2, enq_rd_we_2, enq_branch_2, enq_ls_2, enq_payload_2};

    // Readiness looks only at the registered count, never at this cycle's dequeue.
    assign enq_ready = (count_reg <= ENQ_LIMIT);
    assign enq_n     = (enq_ready && !flush) ? popcount3(enq_valid) : 2'd0;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_read
            logic [PTR_W-1:0] rd_idx;
            assign rd_idx          = head_reg + PTR_W'(gi);
            assign deq_entry[gi]   = mem_reg[rd_idx];
            assign slot_ls[gi]     = deq_entry[gi].ls;
            assign slot_branch[gi] = deq_entry[gi].branch;
        end
    endgenerate

    issue_grant_select #(.PTR_W(PTR_W)) u_grant (
        .count           (count_reg),
        .rename_ready    (rename_ready),
        .lsq_alloc_ready (lsq_alloc_ready),
        .slot_ls         (slot_ls),
        .slot_branch     (slot_branch),
        .flush           (flush),
        .grant           (grant),
        .deq_n           (deq_n)
    );

    assign decode_valid = grant;
    assign queue_count  = count_reg;

    assign {rs1_arch_0, rs2_arch_0, rd_arch_0, rd_write_enable_0, branch_0, load_store_0, payload_0} = deq_entry[0];
    assign {rs1_arch_1, rs2_arch_1, rd_arch_1, rd_write_enable_1, branch_1, load_store_1, payload_1} = deq_entry[1];
    assign {rs1_arch_2, rs2_arch_2, rd_arch_2, rd_write_enable_2, branch_2, load_store_2, payload_2} = deq_entry[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (enq_ready && enq_valid[k]) begin
                    mem_reg[tail_reg + PTR_W'(k)] <= enq_entry[k];
                end
            end
            tail_reg  <= tail_reg + PTR_W'(enq_n);
            head_reg  <= head_reg + PTR_W'(deq_n);
            count_reg <= count_reg + (PTR_W + 1)'(enq_n) - (PTR_W + 1)'(deq_n);
        end
    end

    a_enq_contiguous : assert property (@(posedge clk) disable iff (reset)
        (enq_valid == 3'b000 || enq_valid == 3'b001 || enq_valid == 3'b011 || enq_valid == 3'b111));

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue with a uop scoreboard of queued entries.
module tb_decode_issue_queue;
    import issue_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic clk = 1'b0;
    logic reset, flush;
    logic [2:0] enq_valid, rename_ready, lsq_alloc_ready, decode_valid;
    logic enq_ready;
    logic [PTR_W:0] queue_count;
    uop_entry_t in_e [3];
    uop_entry_t obs_e [3];

    logic [ARCH_ADDR_W-1:0] rs1_arch_0, rs1_arch_1, rs1_arch_2, rs2_arch_0, rs2_arch_1, rs2_arch_2;
    logic [ARCH_ADDR_W-1:0] rd_arch_0, rd_arch_1, rd_arch_2;
    logic rd_write_enable_0, rd_write_enable_1, rd_write_enable_2;
    logic branch_0, branch_1, branch_2, load_store_0, load_store_1, load_store_2;
    logic [UOP_PAYLOAD_W-1:0] payload_0, payload_1, payload_2;

    assign obs_e[0] = {rs1_arch_0, rs2_arch_0, rd_arch_0, rd_write_enable_0, branch_0, load_store_0, payload_0};
    assign obs_e[1] = {rs1_arch_1, rs2_arch_1, rd_arch_1, rd_write_enable_1, branch_1, load_store_1, payload_1};
    assign obs_e[2] = {rs1_arch_2, rs2_arch_2, rd_arch_2, rd_write_enable_2, branch_2, load_store_2, payload_2};

    always #5 clk = ~clk;

    decode_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(UOP_PAYLOAD_W), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .enq_valid(enq_valid),
        .enq_rs1_0(in_e[0].rs1), .enq_rs1_1(in_e[1].rs1), .enq_rs1_2(in_e[2].rs1),
        .enq_rs2_0(in_e[0].rs2), .enq_rs2_1(in_e[1].rs2), .enq_rs2_2(in_e[2].rs2),
        .enq_rd_0(in_e[0].rd), .enq_rd_1(in_e[1].rd), .enq_rd_2(in_e[2].rd),
        .enq_rd_we_0(in_e[0].rd_we), .enq_rd_we_1(in_e[1].rd_we), .enq_rd_we_2(in_e[2].rd_we),
        .enq_branch_0(in_e[0].branch), .enq_branch_1(in_e[1].branch), .enq_branch_2(in_e[2].branch),
        .enq_ls_0(in_e[0].ls), .enq_ls_1(in_e[1].ls), .enq_ls_2(in_e[2].ls),
        .enq_payload_0(in_e[0].payload), .enq_payload_1(in_e[1].payload), .enq_payload_2(in_e[2].payload),
        .enq_ready(enq_ready), .rename_ready(rename_ready), .lsq_alloc_ready(lsq_alloc_ready),
        .decode_valid(decode_valid),
        .rs1_arch_0(rs1_arch_0), .rs1_arch_1(rs1_arch_1), .rs1_arch_2(rs1_arch_2),
        .rs2_arch_0(rs2_arch_0), .rs2_arch_1(rs2_arch_1), .rs2_arch_2(rs2_arch_2),
        .rd_arch_0(rd_arch_0), .rd_arch_1(rd_arch_1), .rd_arch_2(rd_arch_2),
        .rd_write_enable_0(rd_write_enable_0), .rd_write_enable_1(rd_write_enable_1),
        .rd_write_enable_2(rd_write_enable_2),
        .branch_0(branch_0), .branch_1(branch_1), .branch_2(branch_2),
        .load_store_0(load_store_0), .load_store_1(load_store_1), .load_store_2(load_store_2),
        .payload_0(payload_0), .payload_1(payload_1), .payload_2(payload_2),
        .queue_count(queue_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int next_seq = 0;
    uop_entry_t sb [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build a bundle from the running sequence number; a held bundle rebuilds identically.
    task automatic set_bundle(input logic [2:0] v, input logic [2:0] lsm, input logic [2:0] brm);
        enq_valid = v;
        for (int k = 0; k < 3; k++) begin
            int s;
            logic [31:0] s32;
            s = next_seq + k;
            s32 = 32'(s);
            in_e[k].rs1     = 5'(s + 1);
            in_e[k].rs2     = 5'(s + 7);
            in_e[k].rd      = 5'(s);
            in_e[k].rd_we   = s32[0];
            in_e[k].branch  = brm[k];
            in_e[k].ls      = lsm[k];
            in_e[k].payload = {32'hC0DE0000, s32};
        end
    endtask

    function automatic logic [2:0] model_grant();
        logic [2:0] g;
        int lsc, cap;
        logic br, ok;
        g = 3'b000;
        lsc = 0;
        br = 1'b0;
        cap = $countones(lsq_alloc_ready);
        for (int k = 0; k < 3; k++) begin
            ok = 1'b0;
            if (k < sb.size()) begin
                lsc += int'(sb[k].ls);
                ok = rename_ready[k] && (lsc <= cap);
`ifdef ISSUE_SINGLE_BRANCH_EN
                if (br && sb[k].branch) ok = 1'b0;
`endif
                br = br | sb[k].branch;
            end
            if (k > 0 && !g[k-1]) ok = 1'b0;
            g[k] = ok;
        end
        if (flush) g = 3'b000;
        return g;
    endfunction

    // One cycle: check outputs at the falling edge, update the scoreboard, cross the rising edge.
    task automatic step(input string tag);
        logic [2:0] eg;
        logic exp_ready;
        @(negedge clk);
        eg = model_grant();
        exp_ready = (sb.size() <= DEPTH - 3);
        check({tag, ".decode_valid"}, 128'(decode_valid), 128'(eg));
        check({tag, ".enq_ready"}, 128'(enq_ready), 128'(exp_ready));
        check({tag, ".queue_count"}, 128'(queue_count), 128'(sb.size()));
        for (int k = 0; k < 3; k++) begin
            if (k < sb.size()) check($sformatf("%s.slot%0d", tag, k), 128'(obs_e[k]), 128'(sb[k]));
        end
        for (int k = 0; k < 3; k++) begin
            if (eg[k]) void'(sb.pop_front());
        end
        if (flush) begin
            sb.delete();
        end else if (exp_ready) begin
            for (int k = 0; k < 3; k++) begin
                if (enq_valid[k]) begin
                    sb.push_back(in_e[k]);
                    next_seq++;
                end
            end
        end
        $display("step %-10s valid=%b enq_valid=%b rr=%b lsq=%b flush=%b count=%0d", tag,
                 decode_valid, enq_valid, rename_ready, lsq_alloc_ready, flush, queue_count);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        rename_ready = 3'b000;
        lsq_alloc_ready = 3'b000;
        set_bundle(3'b000, 3'b000, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check("rst.decode_valid", 128'(decode_valid), 128'(3'b000));
        check("rst.enq_ready", 128'(enq_ready), 128'(1'b1));
        check("rst.queue_count", 128'(queue_count), 128'(0));
        check("rst.slot0", 128'(obs_e[0]), 128'(0));
        check("rst.slot2", 128'(obs_e[2]), 128'(0));
        reset = 1'b0;

        // Full bundle in, full credit: drains the cycle after it is written.
        rename_ready = 3'b111; lsq_alloc_ready = 3'b111;
        set_bundle(3'b111, 3'b000, 3'b000); step("basic_enq");
        set_bundle(3'b000, 3'b000, 3'b000); step("basic_deq");
        step("empty");

        // Partial rename credit.
        rename_ready = 3'b000;
        set_bundle(3'b111, 3'b000, 3'b000); step("rr_fill");
        rename_ready = 3'b011;
        set_bundle(3'b000, 3'b000, 3'b000); step("rr_011");
        rename_ready = 3'b111; step("rr_tail");

        // LSQ credit limits all-load/store bundle.
        rename_ready = 3'b000;
        set_bundle(3'b111, 3'b111, 3'b000); step("ls_fill");
        rename_ready = 3'b111; lsq_alloc_ready = 3'b001;
        set_bundle(3'b000, 3'b000, 3'b000); step("ls_001");
        lsq_alloc_ready = 3'b011; step("ls_011");
        lsq_alloc_ready = 3'b111; step("ls_done");

        // Fill to 6 with no credit, then the full boundary with a dequeue.
        rename_ready = 3'b000;
        set_bundle(3'b111, 3'b010, 3'b000); step("fill_a");
        set_bundle(3'b111, 3'b000, 3'b000); step("fill_b");
        set_bundle(3'b111, 3'b000, 3'b000); step("fill_held");
        step("fill_held2");
        rename_ready = 3'b001; step("full_deq");
        step("refill");
        rename_ready = 3'b111;
        set_bundle(3'b000, 3'b000, 3'b000);
        repeat (4) step("drain");

        // Pointer wrap with back-to-back bundles.
        for (int b = 0; b < 10; b++) begin
            set_bundle(3'b111, 3'(b), 3'b000);
            step($sformatf("wrap%0d", b));
        end
        set_bundle(3'b011, 3'b000, 3'b000); step("wrap_2wide");
        set_bundle(3'b000, 3'b000, 3'b000);
        repeat (2) step("wrap_drain");

        // Flush with 5 entries and a simultaneous enqueue.
        rename_ready = 3'b000;
        set_bundle(3'b111, 3'b000, 3'b000); step("fl_a");
        set_bundle(3'b011, 3'b000, 3'b000); step("fl_b");
        rename_ready = 3'b111; flush = 1'b1;
        set_bundle(3'b111, 3'b000, 3'b000); step("flush");
        flush = 1'b0;
        set_bundle(3'b000, 3'b000, 3'b000); step("post_flush");

        // Two branches at the head of a group.
        rename_ready = 3'b000;
        set_bundle(3'b111, 3'b000, 3'b011); step("br_fill");
        rename_ready = 3'b111;
        set_bundle(3'b000, 3'b000, 3'b000); step("br_grant");
        repeat (2) step("br_drain");

        // Asynchronous reset mid-operation.
        rename_ready = 3'b000;
        set_bundle(3'b111, 3'b000, 3'b000); step("ar_fill");
        rename_ready = 3'b111;
        set_bundle(3'b000, 3'b000, 3'b000);
        #2 reset = 1'b1;
        #1;
        check("arst.queue_count", 128'(queue_count), 128'(0));
        check("arst.decode_valid", 128'(decode_valid), 128'(3'b000));
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        set_bundle(3'b111, 3'b000, 3'b000); step("ar_first");
        set_bundle(3'b000, 3'b000, 3'b000); step("ar_deq");
        step("ar_empty");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
